// File: rtl/usb_serial_wb_poller.sv
// usb_serial_wb_poller: Wishbone initiator that polls a USB serial peripheral's
// status register. It moves received bytes into a valid/ready RX stream and
// pushes bytes from a valid/ready TX stream into the peripheral's data register.
module usb_serial_wb_poller #(
   parameter logic [7:0] BASE_ADDR   = 8'h00,
   parameter int         POLL_DIV    = 16,
   parameter int         ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   input  logic       wb_ack_i,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       usb_connected,
   output logic       bus_error
);

   localparam int PW = $clog2(POLL_DIV + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_STATUS, S_DECIDE, S_RD_DATA, S_WR_DATA
   } state_t;

   state_t        state, next_state;
   logic [PW-1:0] poll_cnt;
   logic [TW-1:0] to_cnt;
   logic          tx_full;
   logic [7:0]    tx_buf;
   logic          rx_avail, txr;
   logic          burst;
   logic          last_rx;     // arbitration: 1 = last data access was RX

   logic          bus_done, to_hit, rx_elig, tx_elig;
   logic          start_cyc, start_we;
   logic [7:0]    start_adr;

   // An ack only counts while we own the bus; a stray ack with cyc=0 is ignored.
   assign bus_done = wb_cyc_o && wb_ack_i;
   assign to_hit   = wb_cyc_o && !wb_ack_i && (to_cnt == TW'(ACK_TIMEOUT - 1));
   assign rx_elig  = rx_avail && !rx_valid;
   assign tx_elig  = tx_full && txr;
   assign tx_ready = !tx_full;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            // Pending work skips the poll divider but still spends one idle cycle here.
            if (tx_full || burst || (poll_cnt == PW'(POLL_DIV - 1)))
               next_state = S_STATUS;
         end
         S_STATUS: begin
            if (bus_done)    next_state = S_DECIDE;
            else if (to_hit) next_state = S_IDLE;
         end
         S_DECIDE: begin
            if (rx_elig && tx_elig) next_state = last_rx ? S_WR_DATA : S_RD_DATA;
            else if (rx_elig)       next_state = S_RD_DATA;
            else if (tx_elig)       next_state = S_WR_DATA;
            else                    next_state = S_IDLE;
         end
         S_RD_DATA, S_WR_DATA: begin
            if (bus_done || to_hit) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode: launch a bus cycle on entry to any bus-owning state
   always_comb begin
      start_cyc = 1'b0;
      start_we  = 1'b0;
      start_adr = BASE_ADDR;
      if (next_state != state) begin
         case (next_state)
            S_STATUS: begin
               start_cyc = 1'b1;
               start_adr = BASE_ADDR + 8'd1;
            end
            S_RD_DATA: start_cyc = 1'b1;
            S_WR_DATA: begin
               start_cyc = 1'b1;
               start_we  = 1'b1;
            end
            default: start_cyc = 1'b0;
         endcase
      end
   end

   // Registered Wishbone outputs, held until ack or timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= 8'h00;
         wb_dat_o <= 8'h00;
      end else if (bus_done || to_hit) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
      end else if (start_cyc) begin
         wb_cyc_o <= 1'b1;
         wb_stb_o <= 1'b1;
         wb_we_o  <= start_we;
         wb_adr_o <= start_adr;
         wb_dat_o <= start_we ? tx_buf : 8'h00;
      end
   end

   // Ack timeout counter, cleared at the start of every bus cycle
   always_ff @(posedge clk) begin
      if (reset || start_cyc)           to_cnt <= '0;
      else if (wb_cyc_o && !wb_ack_i)   to_cnt <= to_cnt + 1'b1;
   end

   // One-cycle error pulse on an abandoned cycle
   always_ff @(posedge clk) begin
      if (reset) bus_error <= 1'b0;
      else       bus_error <= to_hit;
   end

   // Poll divider runs only while resting in IDLE
   always_ff @(posedge clk) begin
      if (reset)                                          poll_cnt <= '0;
      else if (state == S_IDLE && next_state == S_IDLE)   poll_cnt <= poll_cnt + 1'b1;
      else                                                poll_cnt <= '0;
   end

   // Stream buffers, status capture, burst and arbitration flags
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_full       <= 1'b0;
         tx_buf        <= 8'h00;
         rx_valid      <= 1'b0;
         rx_data       <= 8'h00;
         usb_connected <= 1'b0;
         rx_avail      <= 1'b0;
         txr           <= 1'b0;
         burst         <= 1'b0;
         last_rx       <= 1'b0;
      end else begin
         if (tx_valid && tx_ready) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (to_hit) burst <= 1'b0;
         case (state)
            S_STATUS: if (bus_done) begin
               usb_connected <= wb_dat_i[7];
               rx_avail      <= wb_dat_i[0];
               txr           <= wb_dat_i[1];
            end
            S_DECIDE: if (!rx_elig && !tx_elig) burst <= 1'b0;
            // Only entered with the local RX slot empty, so nothing is overwritten.
            S_RD_DATA: if (bus_done) begin
               rx_data  <= wb_dat_i;
               rx_valid <= 1'b1;
               burst    <= 1'b1;
               last_rx  <= 1'b1;
            end
            S_WR_DATA: if (bus_done) begin
               tx_full <= 1'b0;
               last_rx <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
